ps2_key_receiver: RTL and testbench

- Serial PS/2 keyboard receiver and scan-code-to-key mapper.
- Replaces the combinational frame decoder.
- Samples raw ps2_clk/ps2_data, deserialises and checks 11-bit frames, and tracks make/break (F0) and extended (E0) prefixes.
- Drives a parametrised vector of per-key states, in held or toggle mode, to the LED/game logic.

---
 rtl/ps2_key_pkg.sv | 18 +
 rtl/ps2_frame_rx.sv | 117 +++++++++++
 rtl/ps2_key_receiver.sv | 132 +++++++++++++
 tb/tb_ps2_key_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared constants, types and default key table for the PS/2 key receiver.
// Optional error counter in the top level is enabled with PS2_ERRCNT_EN.
package ps2_key_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } frame_state_t;

  // Packed so that entry i sits at bits [8*i+7 : 8*i]: A D E F G R S T W
  localparam logic [8:0][7:0] DEFAULT_CODES = {
    8'h1D, 8'h2C, 8'h1B, 8'h2D, 8'h34, 8'h2B, 8'h24, 8'h23, 8'h1C
  };

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw bus, detects ps2_clk falling edges,
// deserialises 11-bit frames and flags parity/stop/timeout errors.
module ps2_frame_rx
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  frame_state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]   data_sync_q, data_sync_d;
  logic                     sync_clk_q, sync_clk_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [7:0]               shift_q, shift_d;
  logic                     parity_q, parity_d;

  logic sync_clk;
  logic sync_data;
  logic fall;
  logic timed_out;
  logic frame_ok;

  assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
  assign sync_data = data_sync_q[SYNC_STAGES-1];
  assign fall      = sync_clk_q & ~sync_clk;
  assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES));
  assign frame_ok  = sync_data & (^{shift_q, parity_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      sync_clk_q  <= 1'b1;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      sync_clk_q  <= sync_clk_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
    end
  end

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    sync_clk_d  = sync_clk;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall && !sync_data) begin
          state_d   = RECV;
          bit_cnt_d = 4'd1;
        end
      end
      RECV: begin
        // An edge in the same cycle as the timeout wins and restarts the timer
        if (fall) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            shift_d = {sync_data, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            parity_d = sync_data;
          end else begin
            state_d = IDLE;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_byte  = shift_q;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    if (state_q == RECV) begin
      if (fall && bit_cnt_q == 4'd10) begin
        rx_valid = frame_ok;
        rx_err   = ~frame_ok;
      end else if (!fall && timed_out) begin
        rx_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver top: tracks F0/E0 prefixes and maps scan codes to key bits.
// Define PS2_ERRCNT_EN to add the saturating err_count output.
module ps2_key_receiver
  import ps2_key_pkg::*;
#(
  parameter int                         NUM_KEYS       = 9,
  parameter logic [NUM_KEYS-1:0][7:0]   KEY_CODES      = DEFAULT_CODES,
  parameter int                         TOGGLE_MODE    = 0,
  parameter int                         TIMEOUT_CYCLES = 50000,
  parameter int                         SYNC_STAGES    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] keys,
  output logic [7:0]          code,
  output logic                code_valid,
  output logic                frame_err
`ifdef PS2_ERRCNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic [NUM_KEYS-1:0] keys_q, keys_d, toggled;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [7:0]          code_q, code_d;
  logic                code_valid_q, code_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                brk_q, brk_d;
  logic                ext_q, ext_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_q       <= '0;
      held_q       <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
    end else begin
      keys_q       <= keys_d;
      held_q       <= held_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
    end
  end

  // Errors leave the prefix flags alone so a pending break survives a bad frame
  always_comb begin
    held_d       = held_q;
    toggled      = keys_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    code_d       = code_q;
    code_valid_d = rx_valid;
    frame_err_d  = rx_err;
    if (rx_valid) begin
      code_d = rx_byte;
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!ext_q) begin
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (rx_byte == KEY_CODES[i]) begin
              if (brk_q) begin
                held_d[i] = 1'b0;
              end else if (!held_q[i]) begin
                held_d[i]  = 1'b1;
                toggled[i] = ~keys_q[i];
              end
            end
          end
        end
      end
    end
    keys_d = (TOGGLE_MODE != 0) ? toggled : held_d;
  end

  assign keys       = keys_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

`ifdef PS2_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rx_err && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed self-checking bench for ps2_key_receiver: one held-mode and one toggle-mode
// instance share the same PS/2 bus; err_count is checked when PS2_ERRCNT_EN is defined.
module tb_ps2_key_receiver;
  localparam int TIMEOUT = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] keys, keys_t;
  logic [7:0] code, code_t;
  logic       code_valid, code_valid_t;
  logic       frame_err, frame_err_t;
`ifdef PS2_ERRCNT_EN
  logic [7:0] err_count, err_count_t;
`endif

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ps2_key_receiver #(.TOGGLE_MODE(0), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keys(keys), .code(code), .code_valid(code_valid), .frame_err(frame_err)
`ifdef PS2_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  ps2_key_receiver #(.TOGGLE_MODE(1), .TIMEOUT_CYCLES(TIMEOUT)) dut_t (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keys(keys_t), .code(code_t), .code_valid(code_valid_t), .frame_err(frame_err_t)
`ifdef PS2_ERRCNT_EN
    , .err_count(err_count_t)
`endif
  );

  // Counts every cycle a pulse output is high, so a stuck pulse inflates the count
  always @(negedge clk) begin
    if (code_valid) valid_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(10);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    tick(10);
  endtask

  task automatic send_partial(input int n_bits);
    ps2_bit(1'b0);
    for (int i = 0; i < n_bits; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    tick(5);
    check_output("rst_keys", 32'(keys), 32'h0);
    check_output("rst_code", 32'(code), 32'h0);
    check_output("rst_valid", 32'(code_valid), 32'h0);
    check_output("rst_err", 32'(frame_err), 32'h0);
    check_output("rst_keys_t", 32'(keys_t), 32'h0);
    reset = 1'b0;
    tick(1000);
    check_output("idle_valid_cnt", 32'(valid_cnt), 32'd0);
    check_output("idle_err_cnt", 32'(err_cnt), 32'd0);

    // Press and release A in held mode
    send_frame(8'h1C, 1'b0);
    check_output("pressA_cnt", 32'(valid_cnt), 32'd1);
    check_output("pressA_code", 32'(code), 32'h1C);
    check_output("pressA_keys", 32'(keys), 32'h001);
    check_output("pressA_keys_t", 32'(keys_t), 32'h001);
    send_frame(8'hF0, 1'b0);
    check_output("brk_code", 32'(code), 32'hF0);
    check_output("brk_keys", 32'(keys), 32'h001);
    send_frame(8'h1C, 1'b0);
    check_output("relA_keys", 32'(keys), 32'h000);
    check_output("relA_cnt", 32'(valid_cnt), 32'd3);
    check_output("relA_keys_t", 32'(keys_t), 32'h001);

    // Toggle mode sequence on D
    send_frame(8'h23, 1'b0);
    check_output("tog_press_t", 32'(keys_t), 32'h003);
    check_output("tog_press_h", 32'(keys), 32'h002);
    send_frame(8'h23, 1'b0);
    check_output("tog_repeat_t", 32'(keys_t), 32'h003);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    check_output("tog_break_t", 32'(keys_t), 32'h003);
    check_output("tog_break_h", 32'(keys), 32'h000);
    send_frame(8'h23, 1'b0);
    check_output("tog_second_t", 32'(keys_t), 32'h001);
    check_output("tog_second_h", 32'(keys), 32'h002);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    check_output("tog_clean_h", 32'(keys), 32'h000);
    check_output("tog_clean_t", 32'(keys_t), 32'h001);
    check_output("seq_cnt", 32'(valid_cnt), 32'd10);

    // Bad parity on E
    send_frame(8'h24, 1'b1);
    check_output("par_err_cnt", 32'(err_cnt), 32'd1);
    check_output("par_valid_cnt", 32'(valid_cnt), 32'd10);
    check_output("par_keys", 32'(keys), 32'h000);
`ifdef PS2_ERRCNT_EN
    check_output("par_errcount", 32'(err_count), 32'd1);
`endif

    // Timeout after a partial frame, then a clean F
    send_partial(4);
    tick(TIMEOUT + 100);
    check_output("tmo_err_cnt", 32'(err_cnt), 32'd2);
    check_output("tmo_valid_cnt", 32'(valid_cnt), 32'd10);
    send_frame(8'h2B, 1'b0);
    check_output("tmo_F_keys", 32'(keys), 32'h008);
    check_output("tmo_F_keys_t", 32'(keys_t), 32'h009);
`ifdef PS2_ERRCNT_EN
    check_output("tmo_errcount", 32'(err_count), 32'd2);
`endif

    // Extended prefix never matches the table
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_output("ext_cnt", 32'(valid_cnt), 32'd13);
    check_output("ext_keys", 32'(keys), 32'h008);
    send_frame(8'h1C, 1'b0);
    check_output("plainA_keys", 32'(keys), 32'h009);
    check_output("plainA_keys_t", 32'(keys_t), 32'h008);

    // Frame error between F0 and its code leaves the break pending
    send_frame(8'hF0, 1'b0);
    send_frame(8'h55, 1'b1);
    check_output("pend_err_cnt", 32'(err_cnt), 32'd3);
    send_frame(8'h2B, 1'b0);
    check_output("pend_keys", 32'(keys), 32'h001);
    check_output("pend_keys_t", 32'(keys_t), 32'h008);
`ifdef PS2_ERRCNT_EN
    check_output("pend_errcount", 32'(err_count), 32'd3);
`endif

    // Reset in the middle of a frame discards it
    send_partial(3);
    reset = 1'b1;
    tick(5);
    check_output("midrst_keys", 32'(keys), 32'h000);
    check_output("midrst_code", 32'(code), 32'h00);
`ifdef PS2_ERRCNT_EN
    check_output("midrst_errcount", 32'(err_count), 32'd0);
`endif
    reset = 1'b0;
    tick(20);
    send_frame(8'h1C, 1'b0);
    check_output("postrst_keys", 32'(keys), 32'h001);
    check_output("postrst_keys_t", 32'(keys_t), 32'h001);
    check_output("postrst_code", 32'(code), 32'h1C);
    check_output("postrst_err_cnt", 32'(err_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
